// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point add/sub pipeline: rounding modes
// and width helpers used when sizing parametrised datapaths.
package fxp_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2,
    RND_RSVD      = 2'd3
  } rnd_mode_e;

  function automatic int unsigned max(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

  function automatic int unsigned min(input int unsigned x, input int unsigned y);
    return (x < y) ? x : y;
  endfunction

endpackage

// File: rtl/fxp_round.sv
// Combinational rounder: drops MF-OF fraction bits from a W-bit signed value
// using the selected mode; the result is one bit wider so a carry is kept.
module fxp_round
  import fxp_pkg::*;
#(
  parameter int unsigned W  = 7,
  parameter int unsigned MF = 3,
  parameter int unsigned OF = 2
) (
  input  logic [W-1:0] value_i,
  input  logic [1:0]   round_mode_i,
  output logic [W:0]   rounded_o,
  output logic         inexact_o
);

  localparam int unsigned D = (OF >= MF) ? 0 : MF - OF;

  logic signed [W:0] ext_c;
  assign ext_c = signed'({value_i[W-1], value_i});

  generate
    if (D == 0) begin : g_pass
      // Output has at least as many fraction bits: nothing is discarded.
      logic unused_rnd;
      assign unused_rnd = ^round_mode_i;
      assign rounded_o  = ext_c;
      assign inexact_o  = 1'b0;
    end else begin : g_rnd
      localparam int unsigned RW = W + 1;
      localparam logic [D-1:0] HALF = D'(1) << (D - 1);

      logic [D-1:0]      disc_c;
      logic signed [W:0] floor_c;
      logic              round_up_c;

      assign disc_c  = value_i[D-1:0];
      assign floor_c = ext_c >>> D;

      // Increment decision on top of the two's complement floor.
      always_comb begin
        round_up_c = 1'b0;
        case (rnd_mode_e'(round_mode_i))
          RND_HALF_UP:   round_up_c = disc_c[D-1];
          RND_HALF_EVEN: round_up_c = (disc_c > HALF) || ((disc_c == HALF) && floor_c[0]);
          default:       round_up_c = 1'b0;
        endcase
      end

      assign rounded_o = floor_c + RW'(round_up_c);
      assign inexact_o = |disc_c;
    end
  endgenerate

endmodule

// File: rtl/fxp_addsub_pipe.sv
// Three-stage signed fixed-point add/sub (align+add, round, saturate) with a
// global valid/ready stall and sticky overflow/inexact status.
module fxp_addsub_pipe
  import fxp_pkg::*;
#(
  parameter int unsigned IA = 3,
  parameter int unsigned FA = 3,
  parameter int unsigned IB = 3,
  parameter int unsigned FB = 2,
  parameter int unsigned OI = 3,
  parameter int unsigned OF = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IA+FA-1:0]     a,
  input  logic [IB+FB-1:0]     b,
  input  logic                 sub,
  input  logic [1:0]           round_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OI+OF-1:0]     sum,
  output logic                 ovf,
  output logic                 inexact,
  input  logic                 clr_sticky,
  output logic                 sticky_ovf,
  output logic                 sticky_inexact
);

  localparam int unsigned MI = max(IA, IB);
  localparam int unsigned MF = max(FA, FB);
  localparam int unsigned W  = MI + MF + 1;
  localparam int unsigned RW = W + 1;
  localparam int unsigned SW = OI + OF;
  localparam int unsigned RF = min(OF, MF);
  localparam int unsigned SH = OF - RF;
  localparam int unsigned CW = max(RW + SH, SW) + 1;

  localparam logic signed [CW-1:0] SAT_MAX = (CW'(1) << (SW - 1)) - CW'(1);
  localparam logic signed [CW-1:0] SAT_MIN = -(CW'(1) << (SW - 1));

  logic advance_c;

  logic              s1_valid_q;
  logic [W-1:0]      s1_sum_q,  s1_sum_d;
  logic [1:0]        s1_rnd_q;

  logic              s2_valid_q;
  logic [RW-1:0]     s2_rnd_q,  s2_rnd_d;
  logic              s2_inexact_q, s2_inexact_d;

  logic              out_valid_q;
  logic [SW-1:0]     sum_q,     sum_d;
  logic              ovf_q,     ovf_d;
  logic              inexact_q;
  logic              sticky_ovf_q, sticky_ovf_d;
  logic              sticky_inexact_q, sticky_inexact_d;

  logic signed [W-1:0]  a_al_c, b_al_c;
  logic signed [CW-1:0] s3_ext_c;
  logic                 out_hs_c;

  // Whole pipe moves together unless a result is waiting on the consumer.
  assign advance_c = ~out_valid_q | out_ready;
  assign in_ready  = advance_c;
  assign out_hs_c  = out_valid_q & out_ready;

  // S1: sign-extend integer parts, zero-pad fractions to a common binary point.
  assign a_al_c = W'(signed'(a)) <<< (MF - FA);
  assign b_al_c = W'(signed'(b)) <<< (MF - FB);

  always_comb begin
    s1_sum_d = sub ? W'(a_al_c - b_al_c) : W'(a_al_c + b_al_c);
  end

  // S2: rounding to min(OF, MF) fraction bits.
  fxp_round #(
    .W  (W),
    .MF (MF),
    .OF (OF)
  ) u_round (
    .value_i      (s1_sum_q),
    .round_mode_i (s1_rnd_q),
    .rounded_o    (s2_rnd_d),
    .inexact_o    (s2_inexact_d)
  );

  // S3: pad to OF fraction bits in a width that holds both the value and limits.
  assign s3_ext_c = CW'(signed'(s2_rnd_q)) <<< SH;

  always_comb begin
    sum_d = s3_ext_c[SW-1:0];
    ovf_d = 1'b0;
    if (s3_ext_c > SAT_MAX) begin
      sum_d = {1'b0, {(SW-1){1'b1}}};
      ovf_d = 1'b1;
    end else if (s3_ext_c < SAT_MIN) begin
      sum_d = {1'b1, {(SW-1){1'b0}}};
      ovf_d = 1'b1;
    end
  end

  // Sticky: a flag raised by the handshaking result beats a concurrent clear.
  always_comb begin
    sticky_ovf_d     = clr_sticky ? 1'b0 : sticky_ovf_q;
    sticky_inexact_d = clr_sticky ? 1'b0 : sticky_inexact_q;
    if (out_hs_c && ovf_q)     sticky_ovf_d     = 1'b1;
    if (out_hs_c && inexact_q) sticky_inexact_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance_c) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
    end
  end

  // Internal stage data needs no reset: it is qualified by the stage valids.
  always_ff @(posedge clk) begin
    if (advance_c && in_valid) begin
      s1_sum_q <= s1_sum_d;
      s1_rnd_q <= round_mode;
    end
    if (advance_c && s1_valid_q) begin
      s2_rnd_q     <= s2_rnd_d;
      s2_inexact_q <= s2_inexact_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q            <= '0;
      ovf_q            <= 1'b0;
      inexact_q        <= 1'b0;
      sticky_ovf_q     <= 1'b0;
      sticky_inexact_q <= 1'b0;
    end else begin
      if (advance_c && s2_valid_q) begin
        sum_q     <= sum_d;
        ovf_q     <= ovf_d;
        inexact_q <= s2_inexact_q;
      end
      sticky_ovf_q     <= sticky_ovf_d;
      sticky_inexact_q <= sticky_inexact_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign sum            = sum_q;
  assign ovf            = ovf_q;
  assign inexact        = inexact_q;
  assign sticky_ovf     = sticky_ovf_q;
  assign sticky_inexact = sticky_inexact_q;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Self-checking bench for fxp_addsub_pipe at default Q-formats, using a
// real-arithmetic reference model of align/add, rounding and saturation.
module tb_fxp_addsub_pipe;

  localparam int unsigned IA = 3, FA = 3, IB = 3, FB = 2, OI = 3, OF = 2;

  logic clk, rst;
  logic in_valid, in_ready, sub, out_valid, out_ready;
  logic ovf, inexact, clr_sticky, sticky_ovf, sticky_inexact;
  logic [IA+FA-1:0] a;
  logic [IB+FB-1:0] b;
  logic [1:0] round_mode;
  logic [OI+OF-1:0] sum;

  int n_assert = 0;
  int n_fail = 0;

  fxp_addsub_pipe #(
    .IA(IA), .FA(FA), .IB(IB), .FB(FB), .OI(OI), .OF(OF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .sub            (sub),
    .round_mode     (round_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .sum            (sum),
    .ovf            (ovf),
    .inexact        (inexact),
    .clr_sticky     (clr_sticky),
    .sticky_ovf     (sticky_ovf),
    .sticky_inexact (sticky_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: exact real value, scaled to output LSBs, rounded, clamped.
  // Returns {ovf, inexact, sum}.
  function automatic logic [6:0] ref_model(input logic [5:0] av, input logic [4:0] bv,
                                           input logic s, input logic [1:0] rm);
    real x, sc, fl, fr;
    int r;
    logic [6:0] res;
    x = real'($signed(av)) / 8.0;
    if (s) x = x - real'($signed(bv)) / 4.0;
    else   x = x + real'($signed(bv)) / 4.0;
    sc = x * 4.0;
    fl = $floor(sc);
    fr = sc - fl;
    r  = int'(fl);
    if (rm == 2'd1 && fr >= 0.5) r = r + 1;
    else if (rm == 2'd2 && (fr > 0.5 || (fr == 0.5 && (r % 2) != 0))) r = r + 1;
    res[5] = (fr != 0.0);
    if (r > 15) begin
      res[6] = 1'b1; res[4:0] = 5'b01111;
    end else if (r < -16) begin
      res[6] = 1'b1; res[4:0] = 5'b10000;
    end else begin
      res[6] = 1'b0; res[4:0] = 5'(r);
    end
    return res;
  endfunction

  // Present one transaction on an empty pipe; returns at the negedge where
  // out_valid is seen (or after a bounded wait), lat counts edges from acceptance.
  task automatic send_one(input logic [5:0] av, input logic [4:0] bv, input logic s,
                          input logic [1:0] rm, output int lat);
    @(negedge clk);
    a = av; b = bv; sub = s; round_mode = rm;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    a = '0; b = '0; sub = 1'b0; round_mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_assert++; if (sum !== 5'd0) begin n_fail++; $display("FAIL reset_sum: got %b want 00000", sum); end
    n_assert++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_assert++; if (inexact !== 1'b0) begin n_fail++; $display("FAIL reset_inexact: got %b want 0", inexact); end
    n_assert++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_sticky_ovf: got %b want 0", sticky_ovf); end
    n_assert++; if (sticky_inexact !== 1'b0) begin n_fail++; $display("FAIL reset_sticky_inexact: got %b want 0", sticky_inexact); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_rounding_modes();
    logic [4:0] want [0:2];
    int lat;
    want = '{5'b00110, 5'b00111, 5'b00110};
    for (int m = 0; m < 3; m++) begin
      send_one(6'b001001, 5'b00010, 1'b0, 2'(m), lat);
      n_assert++; if (lat != 3) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 3", m, lat); end
      n_assert++; if (sum !== want[m]) begin n_fail++; $display("FAIL rnd%0d_sum: got %b want %b", m, sum, want[m]); end
      n_assert++; if (inexact !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_inexact: got %b want 1", m, inexact); end
      n_assert++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_ovf: got %b want 0", m, ovf); end
    end
  endtask

  task automatic test_saturation();
    logic [5:0] ta [0:2];
    logic [4:0] tb_v [0:2];
    logic       ts [0:2];
    logic [1:0] tr [0:2];
    logic [6:0] want [0:2];
    int lat;
    ta   = '{6'b011111, 6'b011111, 6'b100000};
    tb_v = '{5'b00100, 5'b00000, 5'b00010};
    ts   = '{1'b0, 1'b0, 1'b1};
    tr   = '{2'd0, 2'd1, 2'd0};
    want = '{{2'b11, 5'b01111}, {2'b11, 5'b01111}, {2'b10, 5'b10000}};
    for (int i = 0; i < 3; i++) begin
      send_one(ta[i], tb_v[i], ts[i], tr[i], lat);
      n_assert++;
      if (out_valid !== 1'b1 || {ovf, inexact, sum} !== want[i]) begin
        n_fail++;
        $display("FAIL sat%0d: got valid=%b {ovf,inexact,sum}=%b want valid=1 %b",
                 i, out_valid, {ovf, inexact, sum}, want[i]);
      end
    end
  endtask

  task automatic test_sticky();
    int lat;
    @(negedge clk) clr_sticky = 1'b1;
    @(posedge clk);
    @(negedge clk) clr_sticky = 1'b0;
    n_assert++;
    if ({sticky_ovf, sticky_inexact} !== 2'b00) begin
      n_fail++; $display("FAIL sticky_clear_initial: got %b want 00", {sticky_ovf, sticky_inexact});
    end
    send_one(6'b011111, 5'b00100, 1'b0, 2'd0, lat);
    clr_sticky = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_assert++;
    if ({sticky_ovf, sticky_inexact} !== 2'b11) begin
      n_fail++; $display("FAIL sticky_set_wins: got %b want 11", {sticky_ovf, sticky_inexact});
    end
    @(posedge clk);
    @(negedge clk) clr_sticky = 1'b0;
    n_assert++;
    if ({sticky_ovf, sticky_inexact} !== 2'b00) begin
      n_fail++; $display("FAIL sticky_clear_alone: got %b want 00", {sticky_ovf, sticky_inexact});
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 12;
    logic [6:0] q [$];
    logic [6:0] e, snap;
    int idx = 0, got = 0, cyc = 0;
    bit acc = 1'b0;
    snap = '0;
    while (got < N && cyc < 200) begin
      @(negedge clk);
      if (acc) idx++;
      in_valid = (idx < N);
      a = 6'(idx * 5 + 3); b = 5'(idx * 7); sub = 1'(idx % 2); round_mode = 2'(idx % 3);
      out_ready = !(cyc >= 2 && cyc < 7);
      #1;
      if (cyc == 2) begin
        n_assert++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          n_fail++; $display("FAIL bp_pre: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
      end
      if (cyc == 3) begin
        n_assert++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_drop: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        snap = {ovf, inexact, sum};
      end
      if (cyc > 3 && cyc < 7) begin
        n_assert++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, inexact, sum} !== snap) begin
          n_fail++; $display("FAIL bp_hold: cyc %0d got valid=%b ready=%b out=%b want 1 0 %b",
                             cyc, out_valid, in_ready, {ovf, inexact, sum}, snap);
        end
      end
      if (cyc == 7) begin
        n_assert++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got in_ready=%b want 1", in_ready); end
      end
      if (out_valid && out_ready) begin
        n_assert++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: unexpected result %b", {ovf, inexact, sum});
        end else begin
          e = q.pop_front();
          if ({ovf, inexact, sum} !== e) begin
            n_fail++; $display("FAIL bp_data #%0d: got %b want %b", got, {ovf, inexact, sum}, e);
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(ref_model(a, b, sub, round_mode));
      cyc++;
    end
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
    n_assert++;
    if (got != N || q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d results, %0d pending, want %0d and 0", got, q.size(), N);
    end
  endtask

  task automatic test_random(input int n, input int rdy_pct, input int vld_pct);
    logic [6:0] q [$];
    logic [6:0] e, held;
    bit acc = 1'b0, hold = 1'b0, hs;
    logic exp_so = 1'b0, exp_si = 1'b0, hs_ovf, hs_inx;
    int sent = 0, got = 0, cyc = 0;
    held = '0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
    @(posedge clk);
    @(negedge clk) clr_sticky = 1'b0;
    while ((sent < n || got < sent) && cyc < 40 * n + 100) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        if (sent < n && $urandom_range(0, 99) < vld_pct) begin
          in_valid = 1'b1;
          a = 6'($urandom); b = 5'($urandom); sub = 1'($urandom); round_mode = 2'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready  = ($urandom_range(0, 99) < rdy_pct);
      clr_sticky = ($urandom_range(0, 15) == 0);
      #1;
      n_assert++;
      if ({sticky_ovf, sticky_inexact} !== {exp_so, exp_si}) begin
        n_fail++; $display("FAIL rnd_sticky cyc %0d: got %b want %b", cyc, {sticky_ovf, sticky_inexact}, {exp_so, exp_si});
      end
      n_assert++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, in_ready, !out_valid || out_ready);
      end
      if (hold) begin
        n_assert++;
        if (out_valid !== 1'b1 || {ovf, inexact, sum} !== held) begin
          n_fail++; $display("FAIL rnd_stall_hold cyc %0d: got valid=%b out=%b want 1 %b", cyc, out_valid, {ovf, inexact, sum}, held);
        end
      end
      hold = out_valid && !out_ready;
      held = {ovf, inexact, sum};
      hs = out_valid && out_ready;
      hs_ovf = 1'b0; hs_inx = 1'b0;
      if (hs) begin
        n_assert++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: unexpected result %b", {ovf, inexact, sum});
        end else begin
          e = q.pop_front();
          hs_ovf = e[6]; hs_inx = e[5];
          if ({ovf, inexact, sum} !== e) begin
            n_fail++; $display("FAIL rnd_data #%0d: got %b want %b", got, {ovf, inexact, sum}, e);
          end
        end
        got++;
      end
      if (clr_sticky) begin
        exp_so = hs_ovf; exp_si = hs_inx;
      end else begin
        exp_so = exp_so | hs_ovf; exp_si = exp_si | hs_inx;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(ref_model(a, b, sub, round_mode));
        sent++;
      end
      cyc++;
    end
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    n_assert++;
    if (got != n || q.size() != 0) begin
      n_fail++; $display("FAIL rnd_count: got %0d results, %0d pending, want %0d and 0", got, q.size(), n);
    end
  endtask

  task automatic test_back_to_back();
    test_random(150, 100, 100);
  endtask

  task automatic test_reset_flush();
    int lat;
    int emitted = 0;
    send_one(6'b011111, 5'b00100, 1'b0, 2'd0, lat);
    @(negedge clk);
    n_assert++;
    if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL flush_pre_sticky: got %b want 1", sticky_ovf); end
    out_ready = 1'b0; in_valid = 1'b1;
    a = 6'b011111; b = 5'b00100; sub = 1'b0; round_mode = 2'd1;
    repeat (3) @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_inflight: got valid=%b ovf=%b want 1 1", out_valid, ovf);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_assert++;
    if ({out_valid, sum, ovf, inexact, sticky_ovf, sticky_inexact} !== 10'd0) begin
      n_fail++; $display("FAIL flush_state: got valid=%b sum=%b ovf=%b inexact=%b sticky=%b%b want all 0",
                         out_valid, sum, ovf, inexact, sticky_ovf, sticky_inexact);
    end
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) emitted++;
    end
    n_assert++;
    if (emitted != 0) begin n_fail++; $display("FAIL flush_emitted: got %0d results want 0", emitted); end
  endtask

  initial begin
    test_reset();
    test_rounding_modes();
    test_saturation();
    test_sticky();
    test_backpressure();
    test_back_to_back();
    test_random(300, 60, 70);
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
